// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if
//   Bundles the write-back buffer's producer, register-file and lookup
//   signals into one interface.
//
//   master : the surrounding pipeline (producers, register file, decode)
//   slave  : the write-back buffer itself
//
//   alu_*     ALU result request channel (valid/ready, rd address, data)
//   ld_*      load result request channel (valid/ready, rd address, data)
//   wb_*      register file write port (enable, address, data)
//   rsN_*     operand lookup (address in, hit + youngest queued value out)
//   count     number of occupied FIFO entries
interface regfile_writeback_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            alu_valid;
    logic [4:0]      alu_rd_addr;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            ld_valid;
    logic [4:0]      ld_rd_addr;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;

    logic            wb_write;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_rd;

    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_hit;
    logic            rs2_hit;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    logic [CW-1:0]   count;

    modport master (
        output alu_valid, alu_rd_addr, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd_addr, ld_data,
        input  ld_ready,
        input  wb_write, wb_rd_addr, wb_rd,
        output rs1_addr, rs2_addr,
        input  rs1_hit, rs2_hit, rs1_fwd, rs2_fwd,
        input  count
    );

    modport slave (
        input  alu_valid, alu_rd_addr, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd_addr, ld_data,
        output ld_ready,
        output wb_write, wb_rd_addr, wb_rd,
        input  rs1_addr, rs2_addr,
        output rs1_hit, rs2_hit, rs1_fwd, rs2_fwd,
        output count
    );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-back buffer between execute/memory and the register file write
//   port. Accepts ALU and load results into a DEPTH-entry FIFO (ALU entry
//   older when both arrive together), drains one entry per cycle to the
//   register file, and answers forwarding lookups for queued results.
//
//   clk    clock, all state on the rising edge
//   reset  asynchronous, active-high; discards every queued entry
//   bus    regfile_writeback_if.slave (request channels, write port,
//          lookups, occupancy count)
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_writeback_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]      addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic [CW-1:0] free;
    logic          alu_push;
    logic          ld_push;
    logic          pop;
    logic [PW-1:0] ld_slot;

    // Readiness looks only at registered occupancy; a drain happening in
    // the same cycle earns no extra credit.
    assign free          = CW'(DEPTH) - count_q;
    assign bus.alu_ready = (free >= CW'(1));
    assign bus.ld_ready  = (free >= CW'(2));

    // Writes to x0 complete the handshake but are never stored.
    assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd_addr != 5'd0);
    assign ld_push  = bus.ld_valid  && bus.ld_ready  && (bus.ld_rd_addr  != 5'd0);
    assign pop      = (count_q != '0);

    // The load entry lands behind the ALU entry when both are stored.
    assign ld_slot = tail_q + PW'(alu_push);

    always_ff @(posedge clk) begin
        if (alu_push) begin
            addr_q[tail_q] <= bus.alu_rd_addr;
            data_q[tail_q] <= bus.alu_data;
        end
        if (ld_push) begin
            addr_q[ld_slot] <= bus.ld_rd_addr;
            data_q[ld_slot] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            tail_q  <= tail_q + PW'(alu_push) + PW'(ld_push);
            count_q <= count_q + CW'(alu_push) + CW'(ld_push) - CW'(pop);
        end
    end

    assign bus.count      = count_q;
    assign bus.wb_write   = pop;
    assign bus.wb_rd_addr = pop ? addr_q[head_q] : '0;
    assign bus.wb_rd      = pop ? data_q[head_q] : '0;

    // Walk occupied entries oldest to youngest so the last match wins,
    // giving the youngest queued value for each lookup address.
    always_comb begin
        logic [PW-1:0] idx;
        idx         = '0;
        bus.rs1_hit = 1'b0;
        bus.rs2_hit = 1'b0;
        bus.rs1_fwd = '0;
        bus.rs2_fwd = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((bus.rs1_addr != 5'd0) && (addr_q[idx] == bus.rs1_addr)) begin
                    bus.rs1_hit = 1'b1;
                    bus.rs1_fwd = data_q[idx];
                end
                if ((bus.rs2_addr != 5'd0) && (addr_q[idx] == bus.rs2_addr)) begin
                    bus.rs2_hit = 1'b1;
                    bus.rs2_fwd = data_q[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk;
    logic reset;

    regfile_writeback_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   n_checks;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Youngest queued value for an address, straight from the queue.
    task automatic lookup(input logic [4:0] rs, output logic hit, output logic [31:0] fwd);
        hit = 1'b0;
        fwd = '0;
        if (rs != 5'd0) begin
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].a == rs) begin
                    hit = 1'b1;
                    fwd = q[i].d;
                end
            end
        end
    endtask

    task automatic check_all();
        int          n;
        logic        h;
        logic [31:0] f;
        n = q.size();
        chk("count",      32'(bus.count),      32'(n));
        chk("alu_ready",  32'(bus.alu_ready),  32'(n < DEPTH));
        chk("ld_ready",   32'(bus.ld_ready),   32'((DEPTH - n) >= 2));
        chk("wb_write",   32'(bus.wb_write),   32'(n > 0));
        chk("wb_rd_addr", 32'(bus.wb_rd_addr), (n > 0) ? 32'(q[0].a) : 32'd0);
        chk("wb_rd",      bus.wb_rd,           (n > 0) ? q[0].d : 32'd0);
        lookup(bus.rs1_addr, h, f);
        chk("rs1_hit",    32'(bus.rs1_hit),    32'(h));
        chk("rs1_fwd",    bus.rs1_fwd,         f);
        lookup(bus.rs2_addr, h, f);
        chk("rs2_hit",    32'(bus.rs2_hit),    32'(h));
        chk("rs2_fwd",    bus.rs2_fwd,         f);
    endtask

    // Drive one cycle's inputs, let them settle, compare against the model.
    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.alu_valid   = av;
        bus.alu_rd_addr = aa;
        bus.alu_data    = ad;
        bus.ld_valid    = lv;
        bus.ld_rd_addr  = la;
        bus.ld_data     = ldd;
        bus.rs1_addr    = r1;
        bus.rs2_addr    = r2;
        #2;
        check_all();
    endtask

    // Apply the handshake rules to the model, then take the clock edge.
    task automatic advance();
        int   n;
        logic acc_a;
        logic acc_l;
        ent_t e;
        n     = q.size();
        acc_a = bus.alu_valid && (n < DEPTH);
        acc_l = bus.ld_valid && ((DEPTH - n) >= 2);
        if (n > 0) void'(q.pop_front());
        if (acc_a && bus.alu_rd_addr != 5'd0) begin
            e.a = bus.alu_rd_addr;
            e.d = bus.alu_data;
            q.push_back(e);
        end
        if (acc_l && bus.ld_rd_addr != 5'd0) begin
            e.a = bus.ld_rd_addr;
            e.d = bus.ld_data;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_rd_addr = '0; bus.alu_data = '0;
        bus.ld_valid  = 1'b0; bus.ld_rd_addr  = '0; bus.ld_data  = '0;
        bus.rs1_addr  = '0;   bus.rs2_addr    = '0;

        // Reset values while reset is held.
        #3;
        check_all();
        chk("rst alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst ld_ready",  32'(bus.ld_ready),  32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single ALU write to x5: visible next cycle, gone the one after.
        drive(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        advance();
        idle(5'd5, 5'd0);
        chk("x5 wb_write", 32'(bus.wb_write),   32'd1);
        chk("x5 wb_addr",  32'(bus.wb_rd_addr), 32'd5);
        chk("x5 wb_rd",    bus.wb_rd,           32'h0000_1234);
        chk("x5 rs1_fwd",  bus.rs1_fwd,         32'h0000_1234);
        advance();
        idle(5'd5, 5'd0);
        chk("x5 drained", 32'(bus.count), 32'd0);
        advance();

        // Same-cycle ALU and load to x1: ALU is older, load is youngest.
        drive(1'b1, 5'd1, 32'hA, 1'b1, 5'd1, 32'hB, 5'd0, 5'd1);
        advance();
        idle(5'd0, 5'd1);
        chk("x1 count",   32'(bus.count), 32'd2);
        chk("x1 rs2_fwd", bus.rs2_fwd,    32'hB);
        chk("x1 first",   bus.wb_rd,      32'hA);
        advance();
        idle(5'd0, 5'd1);
        chk("x1 second",  bus.wb_rd,      32'hB);
        advance();
        idle(5'd0, 5'd0);
        advance();

        // Both producers every cycle: occupancy climbs, ld_ready drops at 3.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(2 * i + 2), 32'h100 + 32'(i), 1'b1, 5'(2 * i + 3), 32'h200 + 32'(i),
                  5'(2 * i + 1), 5'(2 * i));
            if (i == 1) chk("fill count2", 32'(bus.count), 32'd2);
            if (i == 2) begin
                chk("fill count3",   32'(bus.count),     32'd3);
                chk("fill ld_ready", 32'(bus.ld_ready),  32'd0);
                chk("fill alu_rdy",  32'(bus.alu_ready), 32'd1);
            end
            advance();
        end
        for (int i = 0; i < 5; i++) begin
            idle(5'(i + 14), 5'(i + 15));
            advance();
        end

        // Write to x0: handshake only, nothing queued.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("x0 ready", 32'(bus.alu_ready), 32'd1);
        advance();
        idle(5'd0, 5'd0);
        chk("x0 count",   32'(bus.count),    32'd0);
        chk("x0 wb",      32'(bus.wb_write), 32'd0);
        chk("x0 rs1_hit", 32'(bus.rs1_hit),  32'd0);
        chk("x0 rs1_fwd", bus.rs1_fwd,       32'd0);
        advance();

        // Three entries queued, reset mid-cycle clears everything at once.
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 5'd0, 5'd0);
        advance();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 5'd0, 5'd0);
        advance();
        idle(5'd9, 5'd10);
        chk("pre-rst count", 32'(bus.count), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        q.delete();
        chk("rst count",   32'(bus.count),    32'd0);
        chk("rst wb",      32'(bus.wb_write), 32'd0);
        chk("rst rs1_hit", 32'(bus.rs1_hit),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(5'd9, 5'd10);
            advance();
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            advance();
        end
        for (int i = 0; i < 6; i++) begin
            idle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
